// File: rtl/pr3_pkg.sv
// Shared constants and types for the PR3 output framer.
package pr3_pkg;

    localparam logic [15:0] SYNC_HI           = 16'hA5C3;
    localparam int          DEFAULT_FRAME_LEN = 2048;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        TRAILER
    } out_state_e;

endpackage

// File: rtl/pr3_framer_fifo.sv
// Single-clock first-word fall-through FIFO; the head word is visible on
// rd_data whenever the FIFO is not empty.
module pr3_framer_fifo #(
    parameter int FIFO_AW = 12
) (
    input  logic               clk40,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [31:0]        wr_data,
    input  logic               rd_en,
    output logic [31:0]        rd_data,
    output logic               empty,
    output logic [FIFO_AW:0]   occupancy
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   occ_q, occ_d;
    logic               wr_ok;
    logic               rd_ok;

    // Full/empty guards keep the pointers coherent even if a caller misbehaves.
    always_comb begin
        wr_ok    = wr_en && (occ_q != (FIFO_AW + 1)'(DEPTH));
        rd_ok    = rd_en && (occ_q != '0);
        wr_ptr_d = wr_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        occ_d    = occ_q;
        case ({wr_ok, rd_ok})
            2'b10:   occ_d = occ_q + (FIFO_AW + 1)'(1);
            2'b01:   occ_d = occ_q - (FIFO_AW + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk40) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = mem[rd_ptr_q];
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;

endmodule

// File: rtl/pr3_framer.sv
// Groups the unthrottled PR3 word stream into header/payload/checksum frames,
// buffering whole frames and dropping whole frames when space runs out.
module pr3_framer
    import pr3_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int FIFO_AW   = 12
) (
    input  logic        clk40,
    input  logic        reset,
    input  logic        sink_valid,
    input  logic [31:0] sink_data,
    output logic        source_valid,
    input  logic        source_ready,
    output logic [31:0] source_data,
    output logic        source_sof,
    output logic        source_eof,
    output logic [15:0] drop_count
);

    localparam int                 CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [FIFO_AW:0]   DEPTH_W  = (FIFO_AW + 1)'(2 ** FIFO_AW);
    localparam logic [FIFO_AW:0]   FRAME_W  = (FIFO_AW + 1)'(FRAME_LEN);

    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic             admit_q, admit_d;
    logic [15:0]      drop_count_q, drop_count_d;
    logic [FIFO_AW:0] committed_q, committed_d;
    out_state_e       state_q, state_d;
    logic [15:0]      seq_q, seq_d;
    logic [31:0]      csum_q, csum_d;
    logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;

    logic             frame_start;
    logic             admit_now;
    logic             wr_en;
    logic             commit;
    logic             dec;
    logic             rd_en;
    logic [31:0]      rd_data;
    logic             fifo_empty;
    logic [FIFO_AW:0] occupancy;
    logic [FIFO_AW:0] free_space;

    pr3_framer_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk40     (clk40),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (sink_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    // Admission is decided once, on the first word, and held for the frame.
    always_comb begin
        free_space   = DEPTH_W - occupancy;
        frame_start  = (in_cnt_q == '0);
        admit_now    = frame_start ? (free_space >= FRAME_W) : admit_q;
        wr_en        = sink_valid && admit_now;
        commit       = wr_en && (in_cnt_q == LAST_IDX);
        in_cnt_d     = in_cnt_q;
        admit_d      = admit_q;
        drop_count_d = drop_count_q;
        if (sink_valid) begin
            in_cnt_d = (in_cnt_q == LAST_IDX) ? '0 : in_cnt_q + CNT_W'(1);
            if (frame_start) begin
                admit_d = admit_now;
                if (!admit_now && (drop_count_q != 16'hFFFF)) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        csum_d       = csum_q;
        pay_cnt_d    = pay_cnt_q;
        dec          = 1'b0;
        rd_en        = 1'b0;
        source_valid = 1'b0;
        source_data  = '0;
        source_sof   = 1'b0;
        source_eof   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (committed_q != '0) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                source_valid = 1'b1;
                source_data  = {SYNC_HI, seq_q};
                source_sof   = 1'b1;
                if (source_ready) begin
                    state_d   = PAYLOAD;
                    pay_cnt_d = '0;
                end
            end
            PAYLOAD: begin
                source_valid = 1'b1;
                source_data  = rd_data;
                if (source_ready) begin
                    rd_en     = !fifo_empty;
                    csum_d    = csum_q ^ rd_data;
                    pay_cnt_d = pay_cnt_q + CNT_W'(1);
                    if (pay_cnt_q == LAST_IDX) begin
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                source_valid = 1'b1;
                source_data  = csum_q;
                source_eof   = 1'b1;
                if (source_ready) begin
                    seq_d  = seq_q + 16'd1;
                    dec    = 1'b1;
                    csum_d = '0;
                    // Another frame is ready if more than this one was waiting,
                    // or one completes on this very cycle.
                    state_d = ((committed_q > (FIFO_AW + 1)'(1)) || commit) ? HEADER : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        committed_d = committed_q;
        if (commit && !dec) begin
            committed_d = committed_q + (FIFO_AW + 1)'(1);
        end else if (!commit && dec) begin
            committed_d = committed_q - (FIFO_AW + 1)'(1);
        end
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            in_cnt_q     <= '0;
            admit_q      <= 1'b0;
            drop_count_q <= '0;
            committed_q  <= '0;
            state_q      <= IDLE;
            seq_q        <= '0;
            csum_q       <= '0;
            pay_cnt_q    <= '0;
        end else begin
            in_cnt_q     <= in_cnt_d;
            admit_q      <= admit_d;
            drop_count_q <= drop_count_d;
            committed_q  <= committed_d;
            state_q      <= state_d;
            seq_q        <= seq_d;
            csum_q       <= csum_d;
            pay_cnt_q    <= pay_cnt_d;
        end
    end

    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pr3_framer.sv
// Randomized and directed stimulus for pr3_framer checked against a
// frame-level reference model (queue of expected output words).
module tb_pr3_framer;

    localparam int FL    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk40 = 1'b0;
    logic        reset;
    logic        sink_valid;
    logic [31:0] sink_data;
    logic        source_valid;
    logic        source_ready;
    logic [31:0] source_data;
    logic        source_sof;
    logic        source_eof;
    logic [15:0] drop_count;

    pr3_framer #(
        .FRAME_LEN (FL),
        .FIFO_AW   (AW)
    ) dut (
        .clk40        (clk40),
        .reset        (reset),
        .sink_valid   (sink_valid),
        .sink_data    (sink_data),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_data  (source_data),
        .source_sof   (source_sof),
        .source_eof   (source_eof),
        .drop_count   (drop_count)
    );

    always #5 clk40 = ~clk40;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        bit          sof;
        bit          eof;
        bit          pay;
    } item_t;

    item_t       expq[$];
    logic [31:0] cur[$];
    int          occ;
    int          in_cnt;
    bit          admit;
    int          drops;
    logic [15:0] seq_m;
    bit          in_frame;

    task automatic model_reset();
        expq.delete();
        cur.delete();
        occ      = 0;
        in_cnt   = 0;
        admit    = 0;
        drops    = 0;
        seq_m    = 16'h0000;
        in_frame = 0;
    endtask

    // One clock cycle: check visible outputs, drive inputs, advance the model.
    task automatic step(input bit sv, input logic [31:0] d, input bit rdy);
        item_t       it;
        logic [31:0] cs;
        bit          xfer;
        if (source_valid) begin
            if (expq.size() == 0) begin
                check_val("spurious_valid", 32'(source_valid), 32'd0);
            end else begin
                check_val("data", source_data, expq[0].d);
                check_val("sof", 32'(source_sof), 32'(expq[0].sof));
                check_val("eof", 32'(source_eof), 32'(expq[0].eof));
            end
        end else if (in_frame) begin
            check_val("valid_gap", 32'(source_valid), 32'd1);
        end
        sink_valid   = sv;
        sink_data    = d;
        source_ready = rdy;
        xfer = source_valid && rdy && (expq.size() > 0);
        if (sv) begin
            if (in_cnt == 0) begin
                admit = (DEPTH - occ) >= FL;
                cur.delete();
                if (!admit && drops < 16'hFFFF) drops++;
            end
            if (admit) begin
                cur.push_back(d);
                occ++;
            end
            if (in_cnt == FL - 1 && admit) begin
                it = '{d: {16'hA5C3, seq_m}, sof: 1'b1, eof: 1'b0, pay: 1'b0};
                expq.push_back(it);
                cs = 32'h0;
                foreach (cur[i]) begin
                    it = '{d: cur[i], sof: 1'b0, eof: 1'b0, pay: 1'b1};
                    expq.push_back(it);
                    cs ^= cur[i];
                end
                it = '{d: cs, sof: 1'b0, eof: 1'b1, pay: 1'b0};
                expq.push_back(it);
                seq_m++;
            end
            in_cnt = (in_cnt + 1) % FL;
        end
        if (xfer) begin
            it = expq.pop_front();
            if (it.pay) occ--;
            in_frame = !it.eof;
        end
        @(negedge clk40);
        check_val("drop_count", 32'(drop_count), 32'(drops));
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sink_valid   = 1'b0;
        sink_data    = 32'h0;
        source_ready = 1'b0;
        model_reset();
        #1;
        check_val("rst_valid", 32'(source_valid), 32'd0);
        check_val("rst_sof", 32'(source_sof), 32'd0);
        check_val("rst_eof", 32'(source_eof), 32'd0);
        check_val("rst_data", source_data, 32'd0);
        check_val("rst_drop", 32'(drop_count), 32'd0);
        @(negedge clk40);
        reset = 1'b0;
        @(negedge clk40);
    endtask

    task automatic drain(input bit nogap);
        bit seen = 0;
        int k = 0;
        while (expq.size() > 0 && k < 400) begin
            if (nogap && seen) check_val("b2b_gap", 32'(source_valid), 32'd1);
            if (source_valid) seen = 1;
            step(0, 32'h0, 1);
            k++;
        end
        check_val("drain_done", 32'(expq.size()), 32'd0);
        check_val("idle_after", 32'(source_valid), 32'd0);
    endtask

    task automatic feed_frames(input int n, input bit rdy);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < FL; i++) step(1, $urandom, rdy);
        end
    endtask

    initial begin
        reset        = 1'b1;
        sink_valid   = 1'b0;
        sink_data    = 32'h0;
        source_ready = 1'b0;
        @(negedge clk40);
        do_reset();

        // Single frame 1..8, header latency and header word.
        for (int i = 1; i <= FL; i++) step(1, 32'(i), 1);
        check_val("hdr_lat0", 32'(source_valid), 32'd0);
        step(0, 32'h0, 1);
        check_val("hdr_lat1", 32'(source_valid), 32'd1);
        check_val("hdr_word", source_data, 32'hA5C30000);
        drain(1);

        // Back-pressure with ready toggling.
        for (int i = 1; i <= FL; i++) step(1, 32'(i), (i % 2) == 1);
        for (int k = 0; k < 100 && expq.size() > 0; k++) step(0, 32'h0, (k % 2) == 0);
        check_val("bp_done", 32'(expq.size()), 32'd0);

        // Overflow: two buffered, one dropped; then drained back to back.
        do_reset();
        feed_frames(3, 0);
        check_val("ovf_drop", 32'(drop_count), 32'd1);
        check_val("ovf_hdr0", source_data, 32'hA5C30000);
        drain(1);
        feed_frames(2, 0);
        check_val("b2b_hdr2", source_data, 32'hA5C30002);
        drain(1);

        // Four continuous frames with ready high.
        feed_frames(4, 1);
        drain(0);

        // Reset mid-frame discards everything buffered.
        do_reset();
        feed_frames(1, 0);
        for (int i = 0; i < 5; i++) step(1, $urandom, 0);
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 32'h0, 1);
        for (int i = 9; i <= 16; i++) step(1, 32'(i), 1);
        step(0, 32'h0, 1);
        check_val("rst_hdr", source_data, 32'hA5C30000);
        drain(1);

        // Saturating drop counter.
        do_reset();
        force dut.drop_count_q = 16'hFFFE;
        drops = 16'hFFFE;
        step(0, 32'h0, 0);
        release dut.drop_count_q;
        feed_frames(5, 0);
        check_val("drop_sat", 32'(drop_count), 32'h0000FFFF);
        drain(1);
        check_val("drop_hold", 32'(drop_count), 32'h0000FFFF);

        // Randomized traffic with varying back-pressure.
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            int pr = $urandom_range(0, 3);
            for (int c = 0; c < 100; c++) begin
                step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) >= pr);
            end
        end
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
